// File: rtl/wb_reader_pkg.sv
// Shared types and bus encodings for the Wishbone burst reader.
package wb_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    BURST
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 signal bundle between the burst reader (master) and its memory slave.
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  modport master (
    input  clk, rst, ack, dat_sm,
    output adr, dat_ms, cyc, stb, we, sel, cti, bte
  );

  modport slave (
    input  clk, rst, adr, dat_ms, cyc, stb, we, sel, cti, bte,
    output ack, dat_sm
  );
endinterface

// File: rtl/wb_reader_fifo.sv
// Circular FIFO between the Wishbone read path and the stream port.
// Pointers wrap naturally, so DEPTH must be a power of two; pop on empty is ignored.
module wb_reader_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  assign w_pop = pop && (r_count != '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;

endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone master streaming NB_WORDS words via incrementing bursts into a FIFO-backed stream port.
// Define WB_READER_LOOP_EN to restart the pass forever (continuous frame refresh).
module wb_burst_reader #(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          NB_WORDS   = 2048,
  parameter int          BURST_LEN  = 8,
  parameter int          FIFO_DEPTH = 16
) (
  wshb_if.master      wb_m,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready
);
  import wb_reader_pkg::*;

  localparam int WCW = $clog2(NB_WORDS + 1);
  localparam int BCW = $clog2(BURST_LEN);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int FW  = FCW + 1;

  if (NB_WORDS % BURST_LEN != 0) begin : g_bad_nb_words
    $error("NB_WORDS must be a multiple of BURST_LEN");
  end
  if (BURST_LEN < 2) begin : g_bad_burst_len
    $error("BURST_LEN must be at least 2");
  end
  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < BURST_LEN) begin : g_bad_fifo_depth
    $error("FIFO_DEPTH must be a power of two and >= BURST_LEN");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base_addr
    $error("BASE_ADDR must be 4-byte aligned");
  end

  state_t           r_state;
  logic [31:0]      r_adr;
  logic [WCW-1:0]   r_word;
  logic [BCW-1:0]   r_beat;
  logic [2:0]       r_cti;
  logic             r_cyc;
  logic             r_stb;
  logic             r_busy;
  logic             r_done;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic [FCW-1:0]   w_count;
  logic [FW-1:0]    w_free;
  logic             w_last_beat;
  logic             w_last_word;

  assign w_push      = r_stb && wb_m.ack;
  assign w_pop       = !w_empty && dout_ready;
  // Space freed by this cycle's pop counts, so a draining consumer never costs an extra cycle.
  assign w_free      = FW'(FIFO_DEPTH) - {1'b0, w_count} + {{FCW{1'b0}}, w_pop};
  assign w_last_beat = (r_beat == BCW'(BURST_LEN - 1));
  assign w_last_word = (r_word == WCW'(NB_WORDS - 1));

  always_ff @(posedge wb_m.clk or posedge wb_m.rst) begin
    if (wb_m.rst) begin
      r_state <= IDLE;
      r_adr   <= BASE_ADDR;
      r_word  <= '0;
      r_beat  <= '0;
      r_cti   <= CTI_CLASSIC;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= WAIT_SPACE;
            r_busy  <= 1'b1;
            r_word  <= '0;
            r_adr   <= BASE_ADDR;
          end
        end
        WAIT_SPACE: begin
          if (w_free >= FW'(BURST_LEN)) begin
            r_state <= BURST;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_cti   <= CTI_INC;
            r_beat  <= '0;
          end
        end
        BURST: begin
          if (w_push) begin
            r_adr  <= r_adr + 32'd4;
            r_word <= r_word + 1'b1;
            r_beat <= r_beat + 1'b1;
            if (r_beat == BCW'(BURST_LEN - 2)) r_cti <= CTI_EOB;
            if (w_last_beat) begin
              r_cyc   <= 1'b0;
              r_stb   <= 1'b0;
              r_cti   <= CTI_CLASSIC;
              r_state <= WAIT_SPACE;
              if (w_last_word) begin
                r_done <= 1'b1;
`ifdef WB_READER_LOOP_EN
                r_word <= '0;
                r_adr  <= BASE_ADDR;
`else
                r_state <= IDLE;
                r_busy  <= 1'b0;
`endif
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  wb_reader_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_m.clk),
    .rst   (wb_m.rst),
    .push  (w_push),
    .din   (wb_m.dat_sm),
    .pop   (w_pop),
    .dout  (dout),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  a_no_overflow : assert property (@(posedge wb_m.clk) disable iff (wb_m.rst) !(w_push && w_full));

  assign wb_m.adr    = r_adr;
  assign wb_m.cyc    = r_cyc;
  assign wb_m.stb    = r_stb;
  assign wb_m.cti    = r_cti;
  assign wb_m.we     = 1'b0;
  assign wb_m.sel    = 4'hF;
  assign wb_m.bte    = BTE_LINEAR;
  assign wb_m.dat_ms = '0;

  assign busy       = r_busy;
  assign done       = r_done;
  assign dout_valid = !w_empty;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Self-checking bench for wb_burst_reader against a wb_bram-style slave holding mem[i] = i.
// Expected stream and bus beats are derived from word index arithmetic, not from the RTL.
module tb_wb_burst_reader;
  localparam logic [31:0] BASE = 32'h0;
  localparam int NB = 32;
  localparam int BL = 8;
  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        dout_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        dout_valid;
  logic [31:0] dout;

  wshb_if wb (.clk(clk), .rst(rst));

  wb_burst_reader #(
    .BASE_ADDR  (BASE),
    .NB_WORDS   (NB),
    .BURST_LEN  (BL),
    .FIFO_DEPTH (FD)
  ) dut (
    .wb_m       (wb),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  // Slave: combinational ack after a random number of wait cycles per beat.
  logic [31:0] mem [64];
  int max_wait = 0;
  int wait_cnt;

  initial for (int i = 0; i < 64; i++) mem[i] = 32'(i);

  always_comb begin
    wb.ack    = wb.cyc && wb.stb && (wait_cnt == 0);
    wb.dat_sm = mem[wb.adr[7:2]];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (wb.cyc && wb.stb)
      wait_cnt <= (wait_cnt == 0) ? int'($urandom_range(max_wait, 0)) : wait_cnt - 1;
  end

  // Scoreboard
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] got[$];
  logic [31:0] beat_adr[$];
  logic [2:0]  beat_cti[$];
  int          done_cnt;
  logic        pend;
  logic [31:0] pend_adr;
  logic [2:0]  pend_cti;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_sb();
    got.delete();
    beat_adr.delete();
    beat_cti.delete();
    done_cnt = 0;
    pend     = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    start      = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_sb();
  endtask

  // Called at a negedge with next-edge inputs already applied: records what the coming edge
  // will transfer, then advances to the following negedge.
  task automatic cycle();
    if (dout_valid && dout_ready) got.push_back(dout);
    if (wb.cyc && wb.stb) begin
      if (pend) begin
        check("adr_stable_while_stalled", wb.adr, pend_adr);
        check("cti_stable_while_stalled", 32'(wb.cti), 32'(pend_cti));
      end
      if (wb.ack) begin
        beat_adr.push_back(wb.adr);
        beat_cti.push_back(wb.cti);
        check("beat_we", 32'(wb.we), 32'h0);
        check("beat_sel", 32'(wb.sel), 32'hF);
        check("beat_bte", 32'(wb.bte), 32'h0);
        pend = 1'b0;
      end else begin
        pend     = 1'b1;
        pend_adr = wb.adr;
        pend_cti = wb.cti;
      end
    end else begin
      if (pend) check("stb_held_until_ack", 32'(wb.stb), 32'h1);
      pend = 1'b0;
    end
    @(negedge clk);
    if (done) done_cnt++;
  endtask

  task automatic run_until_done(input int target, input int budget, input bit rand_ready);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      if (rand_ready) dout_ready = 1'($urandom_range(1, 0));
      cycle();
      n++;
    end
    check("done_within_budget", 32'(done_cnt >= target), 32'h1);
  endtask

  task automatic check_stream(input string tag);
    for (int k = 0; k < got.size(); k++)
      check({tag, "_data"}, got[k], 32'(k % NB));
    for (int k = 0; k < beat_adr.size(); k++) begin
      check({tag, "_adr"}, beat_adr[k], BASE + 32'(4 * (k % NB)));
      check({tag, "_cti"}, 32'(beat_cti[k]), (k % BL == BL - 1) ? 32'h7 : 32'h2);
    end
  endtask

  task automatic drain(input int n);
    dout_ready = 1'b1;
    repeat (n) cycle();
  endtask

  initial begin
    clear_sb();
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_cyc", 32'(wb.cyc), 32'h0);
    check("rst_stb", 32'(wb.stb), 32'h0);
    check("rst_we", 32'(wb.we), 32'h0);
    check("rst_sel", 32'(wb.sel), 32'hF);
    check("rst_cti", 32'(wb.cti), 32'h0);
    check("rst_bte", 32'(wb.bte), 32'h0);
    check("rst_dat_ms", wb.dat_ms, 32'h0);
    check("rst_adr", wb.adr, BASE);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_dout_valid", 32'(dout_valid), 32'h0);

`ifdef WB_READER_LOOP_EN
    // Continuous refresh: pass wraps to word 0 at BASE, busy never drops, start ignored.
    max_wait = 1;
    do_reset();
    dout_ready = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    begin
      int n = 0;
      int busy_low = 0;
      while (got.size() < 40 && n < 2000) begin
        start = (n % 11 == 5);
        cycle();
        if (!busy) busy_low++;
        n++;
      end
      start = 1'b0;
      check("loop_words_within_budget", 32'(got.size() >= 40), 32'h1);
      check("loop_busy_never_drops", 32'(busy_low), 32'h0);
    end
    check("loop_done_once", 32'(done_cnt), 32'h1);
    check("loop_word32_is_mem0", (got.size() > 32) ? got[32] : 32'hDEAD_BEEF, 32'h0);
    check("loop_beat32_adr", (beat_adr.size() > 32) ? beat_adr[32] : 32'hDEAD_BEEF, BASE);
    check_stream("loop");
`else
    // Plain pass, consumer always ready, no stalls.
    max_wait = 0;
    do_reset();
    dout_ready = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("lat_cyc_low_after_start", 32'(wb.cyc), 32'h0);
    check("lat_busy_after_start", 32'(busy), 32'h1);
    cycle();
    check("lat_cyc_high_2_cycles", 32'(wb.cyc), 32'h1);
    check("lat_first_adr", wb.adr, BASE);
    check("lat_first_cti", 32'(wb.cti), 32'h2);
    check("lat_valid_before_ack", 32'(dout_valid), 32'h0);
    cycle();
    check("lat_valid_after_ack", 32'(dout_valid), 32'h1);
    check("lat_first_dout", dout, 32'h0);
    run_until_done(1, 500, 1'b0);
    check("done_after_last_beat", 32'(beat_adr.size()), 32'(NB));
    check("busy_low_at_done", 32'(busy), 32'h0);
    drain(20);
    check("plain_nwords", 32'(got.size()), 32'(NB));
    check("plain_nbeats", 32'(beat_adr.size()), 32'(NB));
    check("plain_done_once", 32'(done_cnt), 32'h1);
    check("plain_idle_cyc", 32'(wb.cyc), 32'h0);
    check("plain_drained", 32'(dout_valid), 32'h0);
    check_stream("plain");

    // Backpressure: FIFO fills, master parks in WAIT_SPACE until 8 entries are freed.
    max_wait = 0;
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (60) cycle();
    check("bp_beats_when_full", 32'(beat_adr.size()), 32'd16);
    check("bp_nothing_popped", 32'(got.size()), 32'h0);
    check("bp_cyc_parked", 32'(wb.cyc), 32'h0);
    check("bp_busy", 32'(busy), 32'h1);
    check("bp_head", dout, 32'h0);
    dout_ready = 1'b1;
    repeat (8) cycle();
    dout_ready = 1'b0;
    begin
      int n = 0;
      while (beat_adr.size() < 17 && n < 40) begin
        cycle();
        n++;
      end
    end
    check("bp_resume_adr", (beat_adr.size() > 16) ? beat_adr[16] : 32'hDEAD_BEEF, BASE + 32'h40);
    dout_ready = 1'b1;
    run_until_done(1, 500, 1'b0);
    drain(20);
    check("bp_nwords", 32'(got.size()), 32'(NB));
    check_stream("bp");

    // Slave wait states and a random consumer.
    max_wait = 3;
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_until_done(1, 2000, 1'b1);
    drain(40);
    check("stall_nwords", 32'(got.size()), 32'(NB));
    check("stall_nbeats", 32'(beat_adr.size()), 32'(NB));
    check_stream("stall");

    // Async reset on beat 4 of burst 2, then restart from BASE.
    max_wait = 0;
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    begin
      int n = 0;
      while (beat_adr.size() < 11 && n < 200) begin
        cycle();
        n++;
      end
    end
    check("mid_reached_beat", 32'(beat_adr.size()), 32'd11);
    check("mid_cyc_before_rst", 32'(wb.cyc), 32'h1);
    check("mid_valid_before_rst", 32'(dout_valid), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("mid_cyc_dropped", 32'(wb.cyc), 32'h0);
    check("mid_stb_dropped", 32'(wb.stb), 32'h0);
    check("mid_fifo_flushed", 32'(dout_valid), 32'h0);
    check("mid_busy_cleared", 32'(busy), 32'h0);
    @(negedge clk);
    check("mid_no_done", 32'(done), 32'h0);
    check("mid_done_count", 32'(done_cnt), 32'h0);
    rst = 1'b0;
    clear_sb();
    dout_ready = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_until_done(1, 500, 1'b0);
    drain(20);
    check("restart_nwords", 32'(got.size()), 32'(NB));
    check_stream("restart");

    // Start pulses while busy are ignored.
    max_wait = 2;
    do_reset();
    dout_ready = 1'b1;
    start = 1'b1;
    cycle();
    begin
      int n = 0;
      while (done_cnt < 1 && n < 1000) begin
        start = (n % 7 == 3);
        cycle();
        n++;
      end
    end
    start = 1'b0;
    check("busy_start_done_seen", 32'(done_cnt), 32'h1);
    drain(40);
    check("busy_start_nwords", 32'(got.size()), 32'(NB));
    check("busy_start_nbeats", 32'(beat_adr.size()), 32'(NB));
    check("busy_start_done_once", 32'(done_cnt), 32'h1);
    check("busy_start_idle", 32'(busy), 32'h0);
    check_stream("busy_start");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
